shift_rows_col_serializer: RTL and testbench
============================================

// Module: shift_rows_col_serializer
// PURPOSE
// - Upstream feeder for the 32-bit column mixer. Accepts one 128-bit AES state
//   (post-SubBytes) over a valid/ready handshake.
// - Applies ShiftRows at capture, then emits the four shifted 32-bit columns,
//   one per handshake beat, to the column-serial MixColumns stage.
// - Carries a final-round tag so downstream can bypass MixColumns in round 10.
// PARAMETERS
// - BYTE_W          8  byte width; only 8 is supported.
// - ALLOW_BACK2BACK 1  1: a new state may load in the same cycle the col3 beat
//                      completes. 0: always return to IDLE for 1 cycle.
// PORTS
// - clk            in   1    single clock, rising edge.
// - rst_n          in   1    asynchronous, active-low reset.
// - in_valid       in   1    in_state and in_last_round are valid.
// - in_ready       out  1    block can accept a state this cycle.
// - in_state       in   128  [0:127]; byte k = in_state[8k:8k+7]; k = 4*col+row.
// - in_last_round  in   1    sideband tag, captured with the state.
// - out_valid      out  1    out_col is valid.
// - out_ready      in   1    downstream accepts out_col this cycle.
// - out_col        out  32   [0:31]; row0 in [0:7] ... row3 in [24:31].
// - out_idx        out  2    column index (0..3) of out_col.
// - out_last_col   out  1    high when out_idx==3.
// - out_last_round out  1    captured in_last_round, held for all 4 beats.
// - inv            in   1    present only with INV_SHIFT_ROWS_EN; see CONFIGURATION.
// BEHAVIOUR
// - Reset (rst_n low, async): state=IDLE, out_valid=0, out_idx=0, column regs=0,
//   out_last_round=0, in_ready=0. After rst_n rises: in_ready=1 (IDLE).
// - FSM IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture the four
//   shifted columns and the tag. Set idx=0. Next state is SEND.
// - Shift at capture: col[c].row[r] = in byte 4*((c+r)%4)+r.
// - FSM SEND: out_valid=1, out_col=col[idx].
//   - On out_valid&&out_ready: idx<3 -> idx+1.
//   - idx==3 -> if ALLOW_BACK2BACK and in_valid, load the new state, set idx=0 and
//     stay in SEND. Otherwise go to IDLE.
// - in_ready in SEND = ALLOW_BACK2BACK && idx==3 && out_ready. It is combinational
//   from out_ready. No other comb path exists from input to output.
// - Latency: accepted at edge N -> col0 valid in cycle N+1. With no stall the
//   columns appear in cycles N+1..N+4.
// - Throughput: 1 state per 4 cycles when back-to-back; per 5 cycles otherwise.
// - Stall: while out_valid&&!out_ready, out_col, out_idx, out_last_col and
//   out_last_round stay stable.
// - in_valid while busy (not at col3 handshake): ignored, in_ready=0. The
//   upstream holds the data.
// - Reset mid-burst: remaining columns are discarded. No partial output after reset.
// CONFIGURATION
// - INV_SHIFT_ROWS_EN defined: adds port inv (in, 1), sampled at capture.
//   - inv=1 applies InvShiftRows for decryption: col[c].row[r] = in byte
//     4*((c-r+4)%4)+r.
//   - inv=0 gives forward ShiftRows.
// - INV_SHIFT_ROWS_EN not defined: no inv port; forward ShiftRows only.
// TESTING
// - FIPS-197 App.B rd1: in d42711aee0bf98f1b8b45de51e415230, out_ready=1
//   -> cols d4bf5d30, e0b452ae, b84111f1, 1e2798e5; idx 0..3; last_col on beat 4.
// - Index map: in 000102..0f -> cols 00050a0f, 04090e03, 080d0207, 0c01060b.
// - Stall: drop out_ready for 3 cycles on idx1 -> out_col=04090e03 held, no
//   beat lost, in_ready=0 throughout.
// - Back-to-back (ALLOW_BACK2BACK=1): in_valid held with 2 states -> 8
//   consecutive out_valid beats, no bubble. With ALLOW_BACK2BACK=0 -> exactly
//   1 idle cycle between bursts.
// - Reset: assert rst_n low during idx2 -> out_valid=0 immediately, in_ready=0.
//   After release, a new state emits from col0. Tag: in_last_round=1 ->
//   out_last_round=1 on all 4 beats.
// - INV_SHIFT_ROWS_EN, inv=1, in 000102..0f -> cols 000d0a07, 04010e0b,
//   0805020f, 0c090603.

Source files
------------

// File: rtl/shift_rows_col_serializer.sv
// Accepts a 128-bit AES state, applies (Inv)ShiftRows at capture and streams the four
// shifted columns out one per valid/ready beat. Optional inv port: define INV_SHIFT_ROWS_EN.
module shift_rows_col_serializer #(
    parameter int BYTE_W          = 8,
    parameter bit ALLOW_BACK2BACK = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:16*BYTE_W-1]    in_state,
    input  logic                    in_last_round,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:4*BYTE_W-1]     out_col,
    output logic [1:0]              out_idx,
    output logic                    out_last_col,
    output logic                    out_last_round
`ifdef INV_SHIFT_ROWS_EN
    ,
    input  logic                    inv
`endif
);

    localparam int COL_W = 4 * BYTE_W;

    // Both ports: a beat transfers on the rising edge where valid && ready; a producer
    // holds its payload stable until then, and ready never waits for valid.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [0:COL_W-1] col_q [4];
    logic [0:COL_W-1] shifted [4];
    logic [1:0]       idx_q;
    logic             last_round_q;
    logic             armed_q;
    logic             load;
    logic             advance;
    logic             clear_idx;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            shifted[c] = '0;
            for (int r = 0; r < 4; r++) begin
`ifdef INV_SHIFT_ROWS_EN
                if (inv) begin
                    shifted[c][BYTE_W*r +: BYTE_W] = in_state[BYTE_W*(4*((c-r+4)%4)+r) +: BYTE_W];
                end else begin
                    shifted[c][BYTE_W*r +: BYTE_W] = in_state[BYTE_W*(4*((c+r)%4)+r) +: BYTE_W];
                end
`else
                shifted[c][BYTE_W*r +: BYTE_W] = in_state[BYTE_W*(4*((c+r)%4)+r) +: BYTE_W];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        clear_idx = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = armed_q;
                if (in_valid && armed_q) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                // Only the col3 handshake can free the capture registers in the same cycle.
                if (ALLOW_BACK2BACK && idx_q == 2'd3) begin
                    in_ready = out_ready;
                end
                if (out_ready) begin
                    if (idx_q != 2'd3) begin
                        advance = 1'b1;
                    end else if (in_valid && in_ready) begin
                        load = 1'b1;
                    end else begin
                        clear_idx = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) begin
                col_q[c] <= '0;
            end
            idx_q        <= 2'd0;
            last_round_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            // Keeps in_ready low until the first clock edge after reset release.
            armed_q <= 1'b1;
            if (load) begin
                for (int c = 0; c < 4; c++) begin
                    col_q[c] <= shifted[c];
                end
                idx_q        <= 2'd0;
                last_round_q <= in_last_round;
            end else if (advance) begin
                idx_q <= idx_q + 2'd1;
            end else if (clear_idx) begin
                idx_q <= 2'd0;
            end
        end
    end

    assign out_col        = col_q[idx_q];
    assign out_idx        = idx_q;
    assign out_last_col   = (idx_q == 2'd3);
    assign out_last_round = last_round_q;

endmodule

// File: tb/tb_shift_rows_col_serializer.sv
// Randomised bench for shift_rows_col_serializer: a byte-level ShiftRows model feeds an
// expected-beat queue that is compared against the DUT every cycle, plus directed cases.
module tb_shift_rows_col_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_state;
    logic         in_last_round;
    logic         out_valid;
    logic         out_ready;
    logic [0:31]  out_col;
    logic [1:0]   out_idx;
    logic         out_last_col;
    logic         out_last_round;
    logic         inv;

    logic         in0_valid;
    logic         in0_ready;
    logic [0:127] in0_state;
    logic         out0_valid;
    logic [0:31]  out0_col;
    logic [1:0]   out0_idx;
    logic         out0_last_col;
    logic         out0_last_round;

`ifdef INV_SHIFT_ROWS_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];
    bit rdy_chk   = 1'b0;
    bit rdy_mode  = 1'b0;
    bit rdy_force = 1'b1;

    shift_rows_col_serializer #(.BYTE_W(8), .ALLOW_BACK2BACK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_last_round(in_last_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
        .out_idx(out_idx), .out_last_col(out_last_col), .out_last_round(out_last_round)
`ifdef INV_SHIFT_ROWS_EN
        , .inv(inv)
`endif
    );

    shift_rows_col_serializer #(.BYTE_W(8), .ALLOW_BACK2BACK(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in0_valid), .in_ready(in0_ready), .in_state(in0_state),
        .in_last_round(1'b0),
        .out_valid(out0_valid), .out_ready(1'b1), .out_col(out0_col),
        .out_idx(out0_idx), .out_last_col(out0_last_col), .out_last_round(out0_last_round)
`ifdef INV_SHIFT_ROWS_EN
        , .inv(1'b0)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    // Row r of the state matrix rotates left by r (right by r for the inverse).
    function automatic logic [0:127] model_shift(input logic [0:127] st, input logic inv_b);
        logic [7:0] m [4][4];
        logic [0:127] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = st[8*(4*c+r) +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[32*c + 8*r +: 8] = (inv_b && INV_EN) ? m[r][(c+4-r)%4] : m[r][(c+r)%4];
        return res;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s @%0t: bound expired", name, $time);
    endtask

    // ---------------- drivers ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    task automatic drive_state(input logic [0:127] st, input logic lr, input logic inv_b);
        bit hs;
        in_valid      = 1'b1;
        in_state      = st;
        in_last_round = lr;
        inv           = inv_b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        timeout_fail("accept_timeout");
    endtask

    // ---------------- scoreboard ----------------
    initial begin
        logic [0:127] cols;
        bit exp_rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_out_valid", 64'(out_valid), 64'd0);
                check("rst_in_ready", 64'(in_ready), 64'd0);
                exp_q.delete();
            end else begin
                exp_rdy = (exp_q.size() == 0) ? 1'b1 : (exp_q.size() == 1 && out_ready);
                if (rdy_chk) check("in_ready", 64'(in_ready), 64'(exp_rdy));
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (out_valid && exp_q.size() != 0) begin
                    check("beat", 64'({out_col, out_idx, out_last_col, out_last_round}),
                          64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    cols = model_shift(in_state, inv);
                    for (int c = 0; c < 4; c++)
                        exp_q.push_back({cols[32*c +: 32], 2'(c), c == 3, in_last_round});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [0:127] fips_in;
    logic [0:127] idx_in;
    logic [0:127] st;
    logic [0:31]  fips_cols [4];
    logic [0:127] m;
    logic [9:0]   pat;
    bit           drop;

    initial begin
        fips_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        idx_in   = 128'h000102030405060708090a0b0c0d0e0f;
        fips_cols[0] = 32'hd4bf5d30;
        fips_cols[1] = 32'he0b452ae;
        fips_cols[2] = 32'hb84111f1;
        fips_cols[3] = 32'h1e2798e5;
        in_valid = 1'b0; in_state = '0; in_last_round = 1'b0; inv = 1'b0;
        in0_valid = 1'b0; in0_state = '0;
        rst_n = 1'b0;

        // model pins
        m = model_shift(fips_in, 1'b0);
        check("model_fips", 64'(m), 64'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
        m = model_shift(idx_in, 1'b0);
        check("model_idx", 64'(m[0:63]), 64'h00050a0f04090e03);
        check("model_idx_hi", 64'(m[64:127]), 64'h080d02070c01060b);
`ifdef INV_SHIFT_ROWS_EN
        m = model_shift(idx_in, 1'b1);
        check("model_inv", 64'(m[0:63]), 64'h000d0a0704010e0b);
        check("model_inv_hi", 64'(m[64:127]), 64'h0805020f0c090603);
`endif

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_col", 64'(out_col), 64'd0);
        check("rst_last_round", 64'(out_last_round), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        rdy_chk = 1'b1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // FIPS-197 round 1, no stall
        drive_state(fips_in, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("fips_col", 64'(out_col), 64'(fips_cols[i]));
            check("fips_idx", 64'(out_idx), 64'(i));
            check("fips_last_col", 64'(out_last_col), 64'(i == 3));
            @(posedge clk); #1;
        end

        // stall three cycles on col1 while a new state waits upstream
        drive_state(idx_in, 1'b0, 1'b0);
        @(posedge clk); #1;
        rdy_force = 1'b0;
        st = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            #2;
            check("stall_col", 64'(out_col), 64'h04090e03);
            check("stall_idx", 64'(out_idx), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            in_valid = 1'b1; in_state = st; in_last_round = 1'b1;
            @(posedge clk); #1;
        end
        rdy_force = 1'b1;
        drive_state(st, 1'b1, 1'b0);

        // back-to-back pair on the main instance
        drive_state({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        drive_state({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        // no-back-to-back instance: one idle cycle between bursts
        in0_valid = 1'b1; in0_state = fips_in;
        @(posedge clk); #1;
        in0_state = idx_in;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            #2;
            pat[i] = out0_valid;
            if (i == 0) check("nb2b_col0_a", 64'(out0_col), 64'hd4bf5d30);
            if (i == 5) check("nb2b_col0_b", 64'(out0_col), 64'h00050a0f);
            drop = !out0_valid && in0_ready;
            @(posedge clk); #1;
            if (drop) in0_valid = 1'b0;
        end
        check("nb2b_pattern", 64'(pat), 64'(10'b0111101111));

        // reset during col2, then a tagged state from col0
        drive_state(idx_in, 1'b0, 1'b0);
        for (int i = 0; i < 10 && out_idx != 2'd2; i++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_idx", 64'(out_idx), 64'd2);
        rdy_chk = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        rdy_chk = 1'b1;
        drive_state(fips_in, 1'b1, 1'b0);
        check("post_rst_idx", 64'(out_idx), 64'd0);
        check("post_rst_col", 64'(out_col), 64'hd4bf5d30);
        check("post_rst_tag", 64'(out_last_round), 64'd1);

        // randomised traffic with random backpressure
        rdy_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            drive_state({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
        end
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0 || out_valid) timeout_fail("drain_timeout");
        rdy_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
